// File: rtl/tsc_timed.sv
// Highway/country traffic signal controller with per-phase timers, all-red clearance and emergency pre-emption.
// Moore FSM: lamps are registered alongside the state, so input changes appear on the lamps one edge later.
module tsc_timed #(
  parameter int TIMER_W         = 8,
  parameter int HWY_MIN_GREEN   = 4,
  parameter int YELLOW_CYC      = 3,
  parameter int ALLRED_CYC      = 2,
  parameter int CNTRY_MAX_GREEN = 8
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       x,
  input  logic       emg,
  output logic [1:0] hwy,
  output logic [1:0] cntry,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    HG  = 3'd0,
    HY  = 3'd1,
    AR1 = 3'd2,
    CG  = 3'd3,
    CY  = 3'd4,
    AR2 = 3'd5
  } st_t;

  localparam logic [1:0] RED = 2'b00;
  localparam logic [1:0] YEL = 2'b01;
  localparam logic [1:0] GRN = 2'b10;

  localparam logic [TIMER_W-1:0] T_MIN_G = TIMER_W'(HWY_MIN_GREEN - 1);
  localparam logic [TIMER_W-1:0] T_YEL   = TIMER_W'(YELLOW_CYC - 1);
  localparam logic [TIMER_W-1:0] T_AR    = TIMER_W'(ALLRED_CYC - 1);
  localparam logic [TIMER_W-1:0] T_MAX_G = TIMER_W'(CNTRY_MAX_GREEN - 1);

  st_t               cur;
  st_t               nxt;
  logic [TIMER_W-1:0] timer;

  // {hwy, cntry} for a given state; every non-listed code decodes to all-red.
  function automatic logic [3:0] lamps(input st_t s);
    case (s)
      HG:      lamps = {GRN, RED};
      HY:      lamps = {YEL, RED};
      CG:      lamps = {RED, GRN};
      CY:      lamps = {RED, YEL};
      default: lamps = {RED, RED};
    endcase
  endfunction

  always_comb begin
    nxt = cur;
    case (cur)
      HG:  if (x && !emg && timer == T_MIN_G) nxt = HY;
      HY:  if (timer == T_YEL) nxt = AR1;
      AR1: begin
        if (emg)                nxt = AR2;
        else if (timer == T_AR) nxt = CG;
      end
      CG:  if (!x || emg || timer == T_MAX_G) nxt = CY;
      CY:  if (timer == T_YEL) nxt = AR2;
      AR2: if (timer == T_AR) nxt = HG;
      default: nxt = HG;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      cur   <= HG;
      timer <= '0;
      hwy   <= GRN;
      cntry <= RED;
    end else begin
      cur <= nxt;
      // Highway green parks the timer at its minimum so a late request is served at once.
      if (nxt != cur)
        timer <= '0;
      else if (cur == HG && timer == T_MIN_G)
        timer <= timer;
      else
        timer <= timer + 1'b1;
      {hwy, cntry} <= lamps(nxt);
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_tsc_timed.sv
// Scoreboarded bench for tsc_timed: a phase/age reference model predicts each edge, a monitor compares.
module tb_tsc_timed;

  logic       clk;
  logic       clear, x, emg;
  logic [1:0] h0, c0, h1, c1;
  logic [2:0] s0, s1;

  tsc_timed u0 (
    .clk(clk), .clear(clear), .x(x), .emg(emg),
    .hwy(h0), .cntry(c0), .state(s0)
  );

  tsc_timed #(.HWY_MIN_GREEN(1), .YELLOW_CYC(1), .ALLRED_CYC(1)) u1 (
    .clk(clk), .clear(clear), .x(x), .emg(emg),
    .hwy(h1), .cntry(c1), .state(s1)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  typedef struct {
    int st;
    int h;
    int c;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int ncmp = 0;
  int nerr = 0;

  // Phase ids match the published state codes; age = edges already spent in the phase.
  localparam int P_HG = 0, P_HY = 1, P_AR1 = 2, P_CG = 3, P_CY = 4, P_AR2 = 5;
  int hwy_lamp[6] = '{2, 1, 0, 0, 0, 0};
  int cty_lamp[6] = '{0, 0, 0, 2, 1, 0};
  int dmin[2] = '{4, 1};
  int dyel[2] = '{3, 1};
  int dar[2]  = '{2, 1};
  int dmax[2] = '{8, 8};
  int mph[2];
  int mage[2];

  task automatic chk(input string nm, input int act, input int req);
    ncmp++;
    if (act != req) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  task automatic model_step(input int i, input bit c, input bit xx, input bit ee);
    int np;
    int spent;
    np    = mph[i];
    spent = mage[i] + 1;
    if (c) begin
      mph[i]  = P_HG;
      mage[i] = 0;
      return;
    end
    case (mph[i])
      P_HG:  if (xx && !ee && spent >= dmin[i]) np = P_HY;
      P_HY:  if (spent == dyel[i]) np = P_AR1;
      P_AR1: if (ee) np = P_AR2; else if (spent == dar[i]) np = P_CG;
      P_CG:  if (!xx || ee || spent == dmax[i]) np = P_CY;
      P_CY:  if (spent == dyel[i]) np = P_AR2;
      default: if (spent == dar[i]) np = P_HG;
    endcase
    if (np != mph[i]) begin
      mph[i]  = np;
      mage[i] = 0;
    end else begin
      mage[i] = spent;
    end
  endtask

  // Drive one cycle of inputs away from the edge and queue what each DUT must show after it.
  task automatic cyc(input bit c, input bit xx, input bit ee);
    exp_t e;
    @(negedge clk);
    clear = c;
    x     = xx;
    emg   = ee;
    for (int i = 0; i < 2; i++) begin
      model_step(i, c, xx, ee);
      e.st = mph[i];
      e.h  = hwy_lamp[mph[i]];
      e.c  = cty_lamp[mph[i]];
      if (i == 0) q0.push_back(e); else q1.push_back(e);
    end
  endtask

  task automatic probe(input string nm, input int req);
    @(posedge clk);
    #2;
    chk(nm, int'(s0), req);
  endtask

  // Monitor: every edge the DUTs present a new phase; pop and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("state0", int'(s0), e.st);
        chk("hwy0", int'(h0), e.h);
        chk("cntry0", int'(c0), e.c);
        chk("safe0", int'(h0 == 2'b00 || c0 == 2'b00), 1);
        chk("legal0", int'(s0 < 3'd6), 1);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("state1", int'(s1), e.st);
        chk("hwy1", int'(h1), e.h);
        chk("cntry1", int'(c1), e.c);
        chk("safe1", int'(h1 == 2'b00 || c1 == 2'b00), 1);
        chk("legal1", int'(s1 < 3'd6), 1);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", ncmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    clear = 1'b1;
    x     = 1'b0;
    emg   = 1'b0;
    mph   = '{P_HG, P_HG};
    mage  = '{0, 0};

    // Idle highway green with no traffic.
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    repeat (50) cyc(0, 0, 0);
    probe("t1_idle_hg", 0);

    // Continuous demand: two full timed rotations.
    repeat (44) cyc(0, 1, 0);

    // Country car leaves after two green cycles.
    cyc(1, 1, 0);
    n = 0;
    while (mph[0] != P_CG && n < 40) begin cyc(0, 1, 0); n++; end
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    probe("t3_cy_after_x_drop", 4);
    repeat (5) cyc(0, 0, 0);
    probe("t3_back_to_hg", 0);

    // Emergency in first country-green cycle.
    n = 0;
    while (mph[0] != P_CG && n < 40) begin cyc(0, 1, 0); n++; end
    cyc(0, 1, 1);
    probe("t4_emg_cg_to_cy", 4);
    n = 0;
    while (mph[0] != P_HG && n < 40) begin cyc(0, 0, 0); n++; end

    // Emergency during all-red skips country green.
    n = 0;
    while (mph[0] != P_AR1 && n < 40) begin cyc(0, 1, 0); n++; end
    cyc(0, 1, 1);
    probe("t4_emg_ar1_to_ar2", 5);
    n = 0;
    while (mph[0] != P_HG && n < 40) begin cyc(0, 1, 0); n++; end

    // Emergency holds highway green despite demand.
    repeat (20) cyc(0, 1, 1);
    probe("t4_emg_hold_hg", 0);

    // Clear mid-yellow, then demand resumes: yellow again four edges later.
    n = 0;
    while (mph[0] != P_CY && n < 60) begin cyc(0, 1, 0); n++; end
    cyc(0, 1, 0);
    cyc(1, 1, 0);
    n = 0;
    begin
      bit seen;
      seen = 1'b0;
      while (!seen && n < 20) begin
        cyc(0, 1, 0);
        n++;
        @(posedge clk);
        #2;
        seen = (s0 == 3'd1);
      end
    end
    chk("t5_hy_delay", n, 4);

    // Randomised traffic with occasional emergencies and resets.
    repeat (600) begin
      cyc(($urandom % 60) == 0, ($urandom % 4) != 0, ($urandom % 12) == 0);
    end

    repeat (3) @(posedge clk);
    #3;
    chk("queue0_drained", q0.size(), 0);
    chk("queue1_drained", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
